mem_port_arbiter: RTL

- Shares the single unified instruction/data memory port of the multi-period CPU between two requesters: instruction fetch (STATE_IF) and data access (STATE_MEM, LW/SW).
- Sequences each access through a fixed memory wait latency and returns a one-cycle acknowledge.
- The control FSM holds its current state until the acknowledge arrives.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; fixed MEM_LAT wait, one-cycle ack.
// Build with ARB_RR_EN defined for round-robin arbitration; default is fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                own_q, own_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                pick_dat;

`ifdef ARB_RR_EN
  // prio_q = 1 means the data side was granted last
  logic prio_q, prio_d;
  assign pick_dat = d_req && (!if_req || !prio_q);
`else
  assign pick_dat = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_RR_EN
    prio_d     = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          own_d   = pick_dat;
          we_d    = pick_dat ? d_we : 1'b0;
          addr_d  = pick_dat ? d_addr : if_addr;
          wdata_d = pick_dat ? d_wdata : '0;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
`ifdef ARB_RR_EN
          prio_d  = pick_dat;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (own_q) begin
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_q      <= own_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_RR_EN
      prio_q     <= prio_d;
`endif
    end
  end

  // Outputs decode from registered state so an async reset drops them at once
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner_d   = own_q;
  assign if_ack    = (state_q == RESP) && !own_q;
  assign d_ack     = (state_q == RESP) && own_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
